// File: rtl/dds_lfm_core.sv
// dds_lfm_core: linear-FM (chirp) direct digital synthesizer.
// A phase accumulator advances by a tuning word that itself ramps by a
// constant every clock. The top LUT_BITS of the phase address a full-cycle
// sine table computed at elaboration; the table output is registered.
module dds_lfm_core #(
  parameter int unsigned        N_PHASE   = 32,
  parameter int unsigned        LUT_BITS  = 10,
  parameter int unsigned        OUT_WIDTH = 16,
  parameter logic [N_PHASE-1:0] INIT_FTW  = N_PHASE'(32'h0000A7C6),
  parameter logic [N_PHASE-1:0] DELTA_FTW = N_PHASE'(32'h00000001)
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam int  LUT_DEPTH = 32'sd1 <<< LUT_BITS;
  localparam real PI        = 3.14159265358979323846;
  localparam real AMP       = real'((32'sd1 <<< (OUT_WIDTH - 32'd1)) - 32'sd1);

  // Table entry k = round(AMP * sin(2*pi*k/depth)), halves rounded away
  // from zero so the table stays odd-symmetric and never reaches -2^(W-1).
  function automatic logic signed [OUT_WIDTH-1:0] sine_entry(input int k);
    real ang;
    real val;
    int  rnd;
    ang = 2.0 * PI * real'(k) / real'(LUT_DEPTH);
    val = AMP * $sin(ang);
    if (val >= 0.0) begin
      rnd = $rtoi(val + 0.5);
    end else begin
      rnd = -$rtoi(0.5 - val);
    end
    return OUT_WIDTH'(rnd);
  endfunction

  logic signed [OUT_WIDTH-1:0] lut_s [LUT_DEPTH];
  logic [LUT_BITS-1:0]         lut_addr_s;
  logic [N_PHASE-1:0]          phase_acc_q;
  logic [N_PHASE-1:0]          phase_acc_d;
  logic [N_PHASE-1:0]          ftw_q;
  logic [N_PHASE-1:0]          ftw_d;
  logic signed [OUT_WIDTH-1:0] dout_q;
  logic signed [OUT_WIDTH-1:0] dout_d;

  // Constant sine table; folds to a ROM / constant mux at synthesis.
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    assign lut_s[k] = sine_entry(k);
  end

  // Phase bits below the table address are simply dropped (no dither).
  assign lut_addr_s = phase_acc_q[N_PHASE-1 -: LUT_BITS];

  // Next-state: both adders wrap modulo 2^N_PHASE; the table read uses the
  // pre-edge phase, giving one clock of output latency.
  always_comb begin
    phase_acc_d = phase_acc_q + ftw_q;
    ftw_d       = ftw_q + DELTA_FTW;
    dout_d      = lut_s[lut_addr_s];
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc_q <= {N_PHASE{1'b0}};
      ftw_q       <= INIT_FTW;
      dout_q      <= {OUT_WIDTH{1'b0}};
    end else begin
      phase_acc_q <= phase_acc_d;
      ftw_q       <= ftw_d;
      dout_q      <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_dds_lfm_core.sv
// Testbench for dds_lfm_core: four instances (chirp, quarter-rate tone,
// constant tone, 16-bit FTW wrap) share one clock and reset. A closed-form
// model (phase = k*F0 + D*k(k-1)/2) predicts every sample each cycle.
module tb_dds_lfm_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] dout_c, dout_q, dout_t, dout_w;

  int checks = 0;
  int errors = 0;
  int kcnt   = 0;
  bit started = 1'b0;
  logic signed [15:0] ref_lut [1024];

  dds_lfm_core dut_c (.clk(clk), .rst(rst), .dout(dout_c));
  dds_lfm_core #(.INIT_FTW(32'h40000000), .DELTA_FTW(32'h00000000))
    dut_q (.clk(clk), .rst(rst), .dout(dout_q));
  dds_lfm_core #(.INIT_FTW(32'h00400000), .DELTA_FTW(32'h00000000))
    dut_t (.clk(clk), .rst(rst), .dout(dout_t));
  dds_lfm_core #(.N_PHASE(16), .INIT_FTW(16'hFFFE), .DELTA_FTW(16'h0001))
    dut_w (.clk(clk), .rst(rst), .dout(dout_w));

  always #5 clk = ~clk;

  // Edges since the last reset edge (0 while reset is applied).
  always @(posedge clk) begin
    if (rst) begin
      kcnt    <= 0;
      started <= 1'b1;
    end else begin
      kcnt <= kcnt + 1;
    end
  end

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s k=%0d actual=%0d expected=%0d", nm, kcnt, act, exp);
    end
  endtask

  function automatic logic [63:0] phase_model(input int nbits, input logic [63:0] f0,
                                              input logic [63:0] d, input int k);
    logic [63:0] kk;
    logic [63:0] mask;
    kk   = 64'(k);
    mask = (64'd1 << nbits) - 64'd1;
    if (k == 0) return 64'd0;
    return (kk * f0 + d * ((kk * (kk - 64'd1)) / 64'd2)) & mask;
  endfunction

  function automatic logic [63:0] ftw_model(input int nbits, input logic [63:0] f0,
                                            input logic [63:0] d, input int k);
    return (f0 + d * 64'(k)) & ((64'd1 << nbits) - 64'd1);
  endfunction

  function automatic logic signed [15:0] dout_model(input int nbits, input logic [63:0] f0,
                                                    input logic [63:0] d, input int k);
    logic [63:0] ph;
    if (k == 0) return 16'sd0;
    ph = phase_model(nbits, f0, d, k - 1);
    return ref_lut[int'(ph >> (nbits - 10))];
  endfunction

  // Per-cycle scoreboard against the closed-form model.
  always @(negedge clk) begin
    if (started) begin
      check("dout_chirp", dout_c, dout_model(32, 64'h0000A7C6, 64'd1, kcnt));
      check("dout_quarter", dout_q, dout_model(32, 64'h40000000, 64'd0, kcnt));
      check("dout_tone", dout_t, dout_model(32, 64'h00400000, 64'd0, kcnt));
      check("dout_wrap", dout_w, dout_model(16, 64'h0000FFFE, 64'd1, kcnt));
      check("ftw_chirp", dut_c.ftw_q, ftw_model(32, 64'h0000A7C6, 64'd1, kcnt));
      check("ftw_wrap", dut_w.ftw_q, ftw_model(16, 64'h0000FFFE, 64'd1, kcnt));
      check("wrap_no_x", 64'($isunknown(dout_w)), 64'd0);
    end
  end

  typedef struct {
    string              name;
    int                 sel;   // 0 = quarter-rate instance, 1 = constant tone
    int                 edge_k;
    logic signed [15:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (kcnt < target && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_k_reached", 64'(kcnt), 64'(target));
  endtask

  initial begin
    // Independent reference sine table.
    for (int i = 0; i < 1024; i++) begin
      real v;
      v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / 1024.0);
      if (v >= 0.0) ref_lut[i] = 16'($rtoi(v + 0.5));
      else          ref_lut[i] = 16'(-$rtoi(0.5 - v));
    end

    vecs.push_back('{"q_e1", 0, 1, 16'sd0});
    vecs.push_back('{"t_e1", 1, 1, 16'sd0});
    vecs.push_back('{"q_e2", 0, 2, 16'sd32767});
    vecs.push_back('{"q_e3", 0, 3, 16'sd0});
    vecs.push_back('{"q_e4", 0, 4, -16'sd32767});
    vecs.push_back('{"q_e5", 0, 5, 16'sd0});
    vecs.push_back('{"q_e6", 0, 6, 16'sd32767});
    vecs.push_back('{"q_e7", 0, 7, 16'sd0});
    vecs.push_back('{"q_e8", 0, 8, -16'sd32767});
    vecs.push_back('{"t_e257", 1, 257, 16'sd32767});
    vecs.push_back('{"t_e513", 1, 513, 16'sd0});
    vecs.push_back('{"t_e769", 1, 769, -16'sd32767});
    vecs.push_back('{"q_e1025", 0, 1025, 16'sd0});
    vecs.push_back('{"t_e1025", 1, 1025, 16'sd0});
    vecs.push_back('{"q_e1026", 0, 1026, 16'sd32767});
    vecs.push_back('{"t_e1281", 1, 1281, 16'sd32767});
    vecs.push_back('{"t_e1537", 1, 1537, 16'sd0});

    // Reset held for 5 clocks.
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_dout", dout_c, 64'sd0);
      check("rst_phase", dut_c.phase_acc_q, 64'd0);
      check("rst_ftw", dut_c.ftw_q, 64'h0000A7C6);
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_after_reset", dout_c, 64'sd0);

    // Table-driven tone vectors.
    foreach (vecs[i]) begin
      wait_k(vecs[i].edge_k);
      if (vecs[i].sel == 0) check(vecs[i].name, dout_q, vecs[i].exp);
      else                  check(vecs[i].name, dout_t, vecs[i].exp);
    end

    // Mid-sweep reset at cycle 3000; also walks the 16-bit FTW wrap.
    wait_k(3000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_dout", dout_c, 64'sd0);
    check("mid_rst_ftw", dut_c.ftw_q, 64'h0000A7C6);
    check("wrap_ftw0", dut_w.ftw_q, 64'h0000FFFE);
    @(negedge clk);
    check("mid_first_dout", dout_c, 64'sd0);
    check("wrap_ftw1", dut_w.ftw_q, 64'h0000FFFF);
    @(negedge clk);
    check("wrap_ftw2", dut_w.ftw_q, 64'h00000000);
    @(negedge clk);
    check("wrap_ftw3", dut_w.ftw_q, 64'h00000001);

    // Closed-form phase milestones of the chirp.
    wait_k(1000);
    check("phase_k1000", dut_c.phase_acc_q, phase_model(32, 64'h0000A7C6, 64'd1, 1000));
    wait_k(10000);
    check("phase_k10000", dut_c.phase_acc_q, phase_model(32, 64'h0000A7C6, 64'd1, 10000));
    wait_k(50000);
    check("phase_k50000", dut_c.phase_acc_q, phase_model(32, 64'h0000A7C6, 64'd1, 50000));
    check("ftw_k50000", dut_c.ftw_q, 64'h0000A7C6 + 64'd50000);

    // Randomized reset pulses; the scoreboard follows every restart.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(20, 200)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
